// File: rtl/cra_pkg.sv
// -----------------------------------------------------------------------------
// cra_pkg
//   Shared definitions for the sequenced ripple-carry adders.
//   - FSM state encodings (kept as plain 2-bit constants so they line up with
//     the existing encodings used by downstream logic and debug tooling).
//   - Helpers that derive the chunk count and chunk-index width from the
//     operand width N and the per-cycle slice width W.
// -----------------------------------------------------------------------------
package cra_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of W-bit chunks an N-bit operand is split into.
  function automatic int cra_chunks(input int n, input int w);
    return n / w;
  endfunction

  // Width of the chunk index register; never narrower than one bit so a
  // single-chunk configuration still has a legal index vector.
  function automatic int cra_idxw(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/cra_slice.sv
// -----------------------------------------------------------------------------
// cra_slice
//   W-bit purely combinational ripple-carry slice.
//   Ports:
//     cin    in   1  carry into bit 0
//     a, b   in   W  slice operands
//     s      out  W  slice sum
//     cout   out  1  carry out of bit W-1
//     c_msb  out  1  carry into bit W-1 (used for signed-overflow detection)
// -----------------------------------------------------------------------------
module cra_slice
  import cra_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  always_comb begin
    logic c;
    c     = cin;
    s     = '0;
    c_msb = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i == W - 1) begin
        c_msb = c;
      end
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/cra_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cra_seq_ctrl
//   Multi-cycle wide ripple-carry adder. N-bit operands are accepted over a
//   valid/ready handshake, then summed W bits per cycle on a single cra_slice
//   instance with the inter-chunk carry held in a register. The finished sum
//   is held on s/cout with out_valid until the consumer takes it.
//
//   Parameters:
//     N  operand/result width (must be a multiple of W)
//     W  slice width processed per cycle
//
//   Ports:
//     clk        in   1  clock, rising edge
//     rst        in   1  synchronous active-high reset
//     in_valid   in   1  operands presented
//     in_ready   out  1  accepting operands (idle only)
//     cin        in   1  carry into bit 0
//     a, b       in   N  operands
//     out_valid  out  1  s/cout hold a finished result
//     out_ready  in   1  consumer takes result
//     s          out  N  registered sum
//     cout       out  1  registered carry out of bit N-1
//     busy       out  1  high while adding or holding a result
//     ovf        out  1  registered signed overflow (CRA_SEQ_OVF_EN only)
//
//   Build option:
//     CRA_SEQ_OVF_EN  when defined, adds the ovf port and register.
// -----------------------------------------------------------------------------
module cra_seq_ctrl
  import cra_pkg::*;
#(
  parameter int N = 128,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         busy
`ifdef CRA_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CHUNKS = cra_chunks(N, W);
  localparam int IDXW   = cra_idxw(CHUNKS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

  if ((W < 1) || (N % W != 0)) begin : g_bad_width
    $error("cra_seq_ctrl: N (%0d) must be a non-zero multiple of W (%0d)", N, W);
  end

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
`ifdef CRA_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
  logic            sl_c_msb;
`else
  logic            sl_c_msb_unused;
`endif

  logic [W-1:0]    sl_a, sl_b, sl_s;
  logic            sl_cout;

  // Select the current chunk of the latched operands.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned i = 0; i < CHUNKS; i++) begin
      if (idx_q == IDXW'(i)) begin
        sl_a = a_q[i*W +: W];
        sl_b = b_q[i*W +: W];
      end
    end
  end

  cra_slice #(
    .W (W)
  ) u_slice (
    .cin   (carry_q),
    .a     (sl_a),
    .b     (sl_b),
    .s     (sl_s),
    .cout  (sl_cout),
`ifdef CRA_SEQ_OVF_EN
    .c_msb (sl_c_msb)
`else
    .c_msb (sl_c_msb_unused)
`endif
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef CRA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          s_d     = '0;
`ifdef CRA_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        for (int unsigned i = 0; i < CHUNKS; i++) begin
          if (idx_q == IDXW'(i)) begin
            s_d[i*W +: W] = sl_s;
          end
        end
        carry_d = sl_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = sl_cout;
`ifdef CRA_SEQ_OVF_EN
          // Overflow: carry into the top bit differs from carry out of it.
          ovf_d   = sl_c_msb ^ sl_cout;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef CRA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef CRA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ADD) || (state_q == ST_DONE);
  assign s         = s_q;
  assign cout      = cout_q;
`ifdef CRA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
